// File: rtl/otter_rfile_sb.sv
// ============================================================================
// Module      : otter_rfile_sb
// Description : Register file (x0 = 0) with an integrated busy scoreboard.
//               Optional write-to-read bypass with the RFILE_BYPASS_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_rfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_r_addr1,
    input  logic [AW-1:0]   i_r_addr2,
    output logic [XLEN-1:0] o_r_rs1,
    output logic [XLEN-1:0] o_r_rs2,
    output logic            o_r_busy1,
    output logic            o_r_busy2,
    input  logic            i_w_en,
    input  logic [AW-1:0]   i_w_addr,
    input  logic [XLEN-1:0] i_w_data,
    input  logic            i_rsv_en,
    input  logic [AW-1:0]   i_rsv_addr,
    input  logic            i_flush,
    output logic [AW:0]     o_busy_cnt
);

    localparam logic [AW:0] C_NREGS = (AW+1)'(NREGS);

    logic [XLEN-1:0] r_regs [0:NREGS-1];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;

    logic             w_wr_ok;
    logic             w_rsv_ok;
    logic             w_rd_ok1;
    logic             w_rd_ok2;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // Addresses beyond the implemented range (non power-of-2 NREGS) are inert.
    assign w_wr_ok  = i_w_en   && (i_w_addr   != '0) && ({1'b0, i_w_addr}   < C_NREGS);
    assign w_rsv_ok = i_rsv_en && (i_rsv_addr != '0) && ({1'b0, i_rsv_addr} < C_NREGS);
    assign w_rd_ok1 = (i_r_addr1 != '0) && ({1'b0, i_r_addr1} < C_NREGS);
    assign w_rd_ok2 = (i_r_addr2 != '0) && ({1'b0, i_r_addr2} < C_NREGS);

    // Reserve is applied after write so the newer instruction keeps ownership;
    // flush then overrides everything.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok)
            w_busy_nxt[i_w_addr] = 1'b0;
        if (w_rsv_ok)
            w_busy_nxt[i_rsv_addr] = 1'b1;
        if (i_flush)
            w_busy_nxt = '0;
        w_busy_nxt[0] = 1'b0;
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int i = 1; i < NREGS; i++)
            w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[i_w_addr] <= i_w_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    assign o_busy_cnt = r_busy_cnt;

    always_comb begin
        o_r_rs1   = w_rd_ok1 ? r_regs[i_r_addr1] : '0;
        o_r_rs2   = w_rd_ok2 ? r_regs[i_r_addr2] : '0;
        o_r_busy1 = w_rd_ok1 ? r_busy[i_r_addr1] : 1'b0;
        o_r_busy2 = w_rd_ok2 ? r_busy[i_r_addr2] : 1'b0;
`ifdef RFILE_BYPASS_EN
        if (w_wr_ok && (i_w_addr == i_r_addr1)) begin
            o_r_rs1   = i_w_data;
            o_r_busy1 = 1'b0;
        end
        if (w_wr_ok && (i_w_addr == i_r_addr2)) begin
            o_r_rs2   = i_w_data;
            o_r_busy2 = 1'b0;
        end
`else
`endif
    end

endmodule

`default_nettype wire
